// File: rtl/nonlinear_pkg.sv
// Shared types and helpers for the nonlinear activation pipeline.
// Latency: n/a (package only).
// Backpressure: n/a.
package nonlinear_pkg;

  // Function select carried with every beat; codes 100..111 are reserved.
  typedef enum logic [2:0] {
    NL_BYPASS = 3'b000,
    NL_RELU   = 3'b001,
    NL_LEAKY  = 3'b010,
    NL_PWL    = 3'b011
  } nl_fun_e;

  // Width of a PWL segment index for a table of `seg` entries.
  function automatic int nl_seg_w(input int seg);
    return (seg > 1) ? $clog2(seg) : 1;
  endfunction

  // Signed clamp of a wide value to a w-bit two's complement range.
  // Works on a 128-bit carrier so one function serves any 2*WIDTH <= 128.
  function automatic logic signed [127:0] sat_w(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/nonlinear_lane.sv
// One lane of the activation datapath: S1 capture, S2 multiply, S3 add/saturate/select.
// Latency: 3 cycles (three enabled register stages). Optional PWL via NONLINEAR_PWL_EN.
// Backpressure: every stage holds while i_adv is low; the top owns the handshake.
module nonlinear_lane
  import nonlinear_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int SEG        = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_adv,
  input  logic [WIDTH-1:0]        i_x,
  input  logic [WIDTH-1:0]        i_slope,
  input  logic [WIDTH-1:0]        i_icpt,
  input  logic [2:0]              i_fun,
  output logic [$clog2(SEG)-1:0]  o_idx,
  output logic [WIDTH-1:0]        o_y
);

  localparam int SEG_W = $clog2(SEG);

  logic signed [WIDTH-1:0] r_s1_x;
  logic signed [WIDTH-1:0] r_s2_x;
  logic [WIDTH-1:0]        r_y;
  logic [WIDTH-1:0]        w_pwl;
  logic [WIDTH-1:0]        w_y_nxt;

  // Operand pipeline: input value travels S1 -> S2 alongside the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_x <= '0;
      r_s2_x <= '0;
    end else if (i_adv) begin
      r_s1_x <= i_x;
      r_s2_x <= r_s1_x;
    end
  end

`ifdef NONLINEAR_PWL_EN
  logic signed [WIDTH-1:0]   r_s1_slope;
  logic signed [WIDTH-1:0]   r_s1_icpt;
  logic signed [WIDTH-1:0]   r_s2_icpt;
  logic signed [2*WIDTH-1:0] r_s2_prod;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [2*WIDTH-1:0] w_sum;

  // Offset-binary top bits: the most negative inputs land in segment 0.
  if (SEG_W == 1) begin : g_idx1
    assign o_idx = ~i_x[WIDTH-1];
  end else begin : g_idxn
    assign o_idx = {~i_x[WIDTH-1], i_x[WIDTH-2 -: SEG_W-1]};
  end

  assign w_prod = ((2*WIDTH)'(r_s1_slope) * (2*WIDTH)'(r_s1_x)) >>> FRAC;
  // The shifted product leaves headroom, so this sum cannot wrap in 2*WIDTH bits.
  assign w_sum  = r_s2_prod + (2*WIDTH)'(r_s2_icpt);
  assign w_pwl  = WIDTH'(sat_w(128'(w_sum), WIDTH));

  // Segment coefficients captured in S1, product and intercept registered in S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_slope <= '0;
      r_s1_icpt  <= '0;
      r_s2_icpt  <= '0;
      r_s2_prod  <= '0;
    end else if (i_adv) begin
      r_s1_slope <= i_slope;
      r_s1_icpt  <= i_icpt;
      r_s2_icpt  <= r_s1_icpt;
      r_s2_prod  <= w_prod;
    end
  end
`else
  // Without the PWL option the coefficient ports are dead; S2 is a plain register.
  logic w_unused_pwl;
  assign w_unused_pwl = ^{i_slope, i_icpt, FRAC[0]};
  assign o_idx        = '0;
  assign w_pwl        = '0;
`endif

  // S3 result select by the function carried with the beat; reserved codes give 0.
  always_comb begin
    w_y_nxt = '0;
    case (i_fun)
      NL_BYPASS: w_y_nxt = r_s2_x;
      NL_RELU:   w_y_nxt = (r_s2_x > 0) ? r_s2_x : '0;
      NL_LEAKY:  w_y_nxt = r_s2_x[WIDTH-1] ? (r_s2_x >>> LEAK_SHIFT) : r_s2_x;
      NL_PWL:    w_y_nxt = w_pwl;
      default:   w_y_nxt = '0;
    endcase
  end

  // S3 output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
    end else if (i_adv) begin
      r_y <= w_y_nxt;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/nonlinear_pipe.sv
// Multi-lane activation unit (bypass/ReLU/leaky/PWL); PWL table enabled by NONLINEAR_PWL_EN.
// Latency: 3 cycles, one beat per cycle, capacity 3 beats.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready = !out_valid || out_ready.
module nonlinear_pipe
  import nonlinear_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int LANES      = 4,
  parameter int SEG        = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic [2:0]               fun_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  input  logic                     cfg_we,
  input  logic [$clog2(SEG)-1:0]   cfg_addr,
  input  logic [WIDTH-1:0]         cfg_slope,
  input  logic [WIDTH-1:0]         cfg_icpt
);

  localparam int SEG_W = nl_seg_w(SEG);

  logic       r_v1, r_v2, r_v3;
  logic [2:0] r_fun1, r_fun2;
  logic       w_adv;

  logic [LANES-1:0][SEG_W-1:0] w_idx;
  logic [LANES-1:0][WIDTH-1:0] w_slope;
  logic [LANES-1:0][WIDTH-1:0] w_icpt;
  logic [LANES-1:0][WIDTH-1:0] w_y;

  // Single global advance: bubbles are squeezed only at the output.
  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;

  // Stage valids and function codes; S3 needs no function copy (result already selected).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_fun1 <= '0;
      r_fun2 <= '0;
    end else if (w_adv) begin
      r_v1   <= in_valid;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_fun1 <= fun_id;
      r_fun2 <= r_fun1;
    end
  end

`ifdef NONLINEAR_PWL_EN
  logic [WIDTH-1:0] r_slope [SEG];
  logic [WIDTH-1:0] r_icpt  [SEG];

  // Coefficient table: writes ignore the stall; a same-edge S1 read sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SEG; s++) begin
        r_slope[s] <= '0;
        r_icpt[s]  <= '0;
      end
    end else if (cfg_we) begin
      r_slope[cfg_addr] <= cfg_slope;
      r_icpt[cfg_addr]  <= cfg_icpt;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{cfg_we, cfg_addr, cfg_slope, cfg_icpt, w_idx};
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef NONLINEAR_PWL_EN
    assign w_slope[i] = r_slope[w_idx[i]];
    assign w_icpt[i]  = r_icpt[w_idx[i]];
`else
    assign w_slope[i] = '0;
    assign w_icpt[i]  = '0;
`endif

    nonlinear_lane #(
      .WIDTH      (WIDTH),
      .FRAC       (FRAC),
      .SEG        (SEG),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_adv   (w_adv),
      .i_x     (in_data[i*WIDTH +: WIDTH]),
      .i_slope (w_slope[i]),
      .i_icpt  (w_icpt[i]),
      .i_fun   (r_fun2),
      .o_idx   (w_idx[i]),
      .o_y     (w_y[i])
    );

    assign out_data[i*WIDTH +: WIDTH] = w_y[i];
  end

endmodule

// File: tb/tb_nonlinear_pipe.sv
// Directed bench for nonlinear_pipe: functions, PWL table, backpressure, reset.
// Expectations for PWL beats depend on whether NONLINEAR_PWL_EN is defined.
// Outputs are sampled 1-2 time units after the rising edge.
module tb_nonlinear_pipe;

`ifdef NONLINEAR_PWL_EN
  localparam bit PWL_ON = 1'b1;
`else
  localparam bit PWL_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [2:0]   fun_id;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [31:0]  cfg_slope;
  logic [31:0]  cfg_icpt;

  int n_chk = 0;
  int n_bad = 0;

  nonlinear_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .fun_id    (fun_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_slope (cfg_slope),
    .cfg_icpt  (cfg_icpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic cfg_wr(input logic [3:0] a, input logic [31:0] s, input logic [31:0] ic);
    cfg_we = 1'b1; cfg_addr = a; cfg_slope = s; cfg_icpt = ic;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Offer one beat into an idle pipe, check latency and result, then let it drain.
  task automatic run_beat(input logic [2:0] f, input logic [127:0] d,
                          input string tag, input logic [127:0] exp);
    int n;
    fun_id = f; in_data = d; in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'd2);
    chk(tag, out_data, exp);
    @(posedge clk); #1;
  endtask

  logic [127:0] bp_dat [5];

  initial begin
    int acc, got, first_out, last_out, n;
    logic in_fire, out_fire;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; fun_id = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_slope = '0; cfg_icpt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pointwise functions
    run_beat(3'b001, pk(32'hFFFFFFFB, 32'd7, 32'd0, 32'h7FFFFFFF), "relu",
             pk(32'd0, 32'd7, 32'd0, 32'h7FFFFFFF));
    run_beat(3'b001, pk(32'h80000000, 32'd1, 32'hFFFFFFFF, 32'd0), "relu_edge",
             pk(32'd0, 32'd1, 32'd0, 32'd0));
    run_beat(3'b010, pk(32'hFFFFFFC0, 32'hFFFFFFFF, 32'd64, 32'd0), "leaky",
             pk(32'hFFFFFFF8, 32'hFFFFFFFF, 32'd64, 32'd0));
    run_beat(3'b010, pk(32'h80000000, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'hFFFFFFF8), "leaky_edge",
             pk(32'hF0000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF));
    run_beat(3'b000, pk(32'h80000000, 32'hFFFFFFFF, 32'd123, 32'h7FFFFFFF), "bypass",
             pk(32'h80000000, 32'hFFFFFFFF, 32'd123, 32'h7FFFFFFF));
    run_beat(3'b111, pk(32'd1, 32'd2, 32'd3, 32'd4), "rsvd7", 128'd0);
    run_beat(3'b100, pk(32'hFFFFFFFF, 32'd2, 32'd3, 32'd4), "rsvd4", 128'd0);

    // PWL: idx 8 = 0.5x + 1.0; other segments still zero
    cfg_wr(4'd8, 32'h00008000, 32'h00010000);
    run_beat(3'b011, pk(32'h00020000, 32'h10000000, 32'hFFFF0000, 32'h00040000), "pwl_basic",
             PWL_ON ? pk(32'h00020000, 32'd0, 32'd0, 32'h00030000) : 128'd0);
    // Saturation: idx 15 covers 0x7FFF0000, idx 0 covers 0x80000000
    cfg_wr(4'd15, 32'h7FFFFFFF, 32'h7FFFFFFF);
    cfg_wr(4'd0, 32'h7FFFFFFF, 32'h80000000);
    run_beat(3'b011, pk(32'h7FFF0000, 32'h80000000, 32'h00020000, 32'd0), "pwl_sat",
             PWL_ON ? pk(32'h7FFFFFFF, 32'h80000000, 32'h00020000, 32'h00010000) : 128'd0);
    // Write idx 8 on the capture edge: this beat uses the old entry, the next one the new
    cfg_we = 1'b1; cfg_addr = 4'd8; cfg_slope = '0; cfg_icpt = '0;
    run_beat(3'b011, {4{32'h00020000}}, "pwl_old", PWL_ON ? {4{32'h00020000}} : 128'd0);
    run_beat(3'b011, {4{32'h00020000}}, "pwl_new", 128'd0);

    // Backpressure: five beats offered with the sink stalled for six cycles
    for (int i = 0; i < 5; i++) begin
      bp_dat[i] = pk(32'(i + 1), 32'(i + 101), 32'(i + 201), 32'(i + 301));
    end
    acc = 0; got = 0; first_out = -1; last_out = -1;
    out_ready = 1'b0; fun_id = 3'b000;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (cyc == 6) begin
        chk("bp_accepted", 128'(acc), 128'd3);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        chk("bp_hold", out_data, bp_dat[0]);
        out_ready = 1'b1;
      end
      if (acc < 5) begin
        in_valid = 1'b1; in_data = bp_dat[acc];
      end else begin
        in_valid = 1'b0; in_data = '0;
      end
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        chk("bp_order", out_data, bp_dat[got]);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      @(posedge clk); #1;
      if (in_fire) acc++;
    end
    in_valid = 1'b0;
    chk("bp_got", 128'(got), 128'd5);
    chk("bp_accepted_all", 128'(acc), 128'd5);
    chk("bp_span", 128'(last_out - first_out), 128'd4);
    repeat (3) @(posedge clk);
    #1;

    // Reset with two beats in flight
    fun_id = 3'b000;
    in_valid = 1'b1; in_data = pk(32'd11, 32'd12, 32'd13, 32'd14);
    @(posedge clk); #1;
    in_data = pk(32'd21, 32'd22, 32'd23, 32'd24);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", 128'(out_valid), 128'd0);
    chk("midrst_data", out_data, 128'd0);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("midrst_stale", 128'(n), 128'd0);
    run_beat(3'b011, pk(32'h00020000, 32'h7FFF0000, 32'h80000000, 32'd0), "midrst_tbl", 128'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
